// File: rtl/load_store_unit.sv
// Data-memory stage: byte/half/word loads and stores over a req/ack word bus.
// Stalls the core while an access is outstanding and aborts after TIMEOUT cycles.
//
//   state  | meaning
//   IDLE   | waiting for MemRead/MemWrite; an illegal request pulses LsuError here
//   ACCESS | bus_req held with registered address/data until ack or timeout
//   DONE   | instruction retires, Stall low, error flag reported then cleared
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        LsuError,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        err_flag;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;

  logic        mem_req;
  logic        is_store;
  logic        illegal;
  logic        accept;
  logic        reject;
  logic        ack_hit;
  logic        timeout_hit;
  logic [1:0]  lane;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_val;

  assign mem_req  = MemRead | MemWrite;
  assign is_store = MemWrite;
  assign lane     = Mem_WrAddr[1:0];

  always_comb begin
    illegal = 1'b1;
    case (Funct3)
      3'b000:         illegal = 1'b0;
      3'b001:         illegal = lane[0];
      3'b010:         illegal = (lane != 2'b00);
      3'b100:         illegal = is_store;
      3'b101:         illegal = is_store | lane[0];
      default:        illegal = 1'b1;
    endcase
  end

  // Stores replicate the datum across lanes so the bus only needs byte enables.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = '0;
    if (is_store) begin
      case (Funct3)
        3'b000: begin
          be_nxt    = 4'b0001 << lane;
          wdata_nxt = {4{Mem_WrData[7:0]}};
        end
        3'b001: begin
          be_nxt    = 4'b0011 << {lane[1], 1'b0};
          wdata_nxt = {2{Mem_WrData[15:0]}};
        end
        default: begin
          be_nxt    = 4'b1111;
          wdata_nxt = Mem_WrData;
        end
      endcase
    end
  end

  always_comb begin
    byte_v = bus_rdata[7:0];
    case (lane_q)
      2'd0:    byte_v = bus_rdata[7:0];
      2'd1:    byte_v = bus_rdata[15:8];
      2'd2:    byte_v = bus_rdata[23:16];
      default: byte_v = bus_rdata[31:24];
    endcase
    half_v = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
      3'b100:  load_val = {24'h0, byte_v};
      3'b001:  load_val = {{16{half_v[15]}}, half_v};
      3'b101:  load_val = {16'h0, half_v};
      default: load_val = bus_rdata;
    endcase
  end

  always_comb begin
    state_nxt   = state;
    Stall       = 1'b0;
    LsuError    = 1'b0;
    accept      = 1'b0;
    reject      = 1'b0;
    ack_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (reset && mem_req) begin
          if (illegal) begin
            reject   = 1'b1;
            LsuError = 1'b1;
          end else begin
            accept    = 1'b1;
            Stall     = 1'b1;
            state_nxt = ACCESS;
          end
        end
      end
      ACCESS: begin
        Stall = 1'b1;
        if (bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nxt   = DONE;
        end
      end
      DONE: begin
        LsuError  = err_flag;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ReadData  <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
    end else begin
      if (accept) begin
        bus_req   <= 1'b1;
        bus_we    <= is_store;
        bus_addr  <= {Mem_WrAddr[31:2], 2'b00};
        bus_wdata <= wdata_nxt;
        bus_be    <= be_nxt;
        f3_q      <= Funct3;
        lane_q    <= lane;
        cnt       <= '0;
        err_flag  <= 1'b0;
      end
      if (state == ACCESS) cnt <= cnt + 8'd1;
      if (ack_hit) begin
        bus_req <= 1'b0;
        if (!bus_we) ReadData <= load_val;
      end
      if (timeout_hit) begin
        bus_req  <= 1'b0;
        ReadData <= '0;
        err_flag <= 1'b1;
      end
      if (reject) ReadData <= '0;
      if (state == DONE) begin
        cnt      <= '0;
        err_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table of accesses with a bus responder,
// a scoreboard of expected load results, and hand-written reset/timeout sequences.
module tb_load_store_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Mem_WrAddr;
  logic [31:0] Mem_WrData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        LsuError;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .Stall(Stall), .LsuError(LsuError),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;     // ACCESS cycles before ack; negative = never ack
    logic        illegal;
    logic [31:0] exp_rd;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t vecs[17];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int waits,
                              input logic illegal, input logic [31:0] exp_rd,
                              input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                              input logic [3:0] exp_be);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.waits = waits; v.illegal = illegal; v.exp_rd = exp_rd;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_be = exp_be;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   stall_n;
    int   acc_n;
    int   exp_stall;
    bit   done;
    exp_stall = (v.waits < 0) ? int'(TO) + 1 : v.waits + 2;
    @(negedge clk);
    MemRead    = v.rd;
    MemWrite   = v.wr;
    Funct3     = v.f3;
    Mem_WrAddr = v.addr;
    Mem_WrData = v.wdata;
    bus_ack    = 1'b0;
    e.rd  = v.exp_rd;
    e.err = v.illegal | (v.waits < 0);
    exp_q.push_back(e);
    #1;
    if (v.illegal) begin
      check($sformatf("v%0d_err_pulse", idx), LsuError, 1'b1);
      check($sformatf("v%0d_err_stall", idx), Stall, 1'b0);
      check($sformatf("v%0d_err_req", idx), bus_req, 1'b0);
      @(negedge clk);
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d_err_rdata", idx), ReadData, e.rd);
      check($sformatf("v%0d_err_one_cycle", idx), LsuError, 1'b0);
      return;
    end
    check($sformatf("v%0d_accept_stall", idx), Stall, 1'b1);
    check($sformatf("v%0d_accept_err", idx), LsuError, 1'b0);
    stall_n = 1;
    acc_n   = 0;
    done    = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      #1;
      if (Stall) begin
        stall_n++;
        check($sformatf("v%0d_req", idx), bus_req, 1'b1);
        check($sformatf("v%0d_addr", idx), bus_addr, v.exp_addr);
        check($sformatf("v%0d_be", idx), bus_be, v.exp_be);
        check($sformatf("v%0d_wdata", idx), bus_wdata, v.exp_wdata);
        check($sformatf("v%0d_we", idx), bus_we, v.wr);
        if (acc_n == v.waits) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end else begin
          bus_rdata = $urandom;
        end
        acc_n++;
      end else begin
        done     = 1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("v%0d_rdata", idx), ReadData, e.rd);
        check($sformatf("v%0d_done_err", idx), LsuError, e.err);
        check($sformatf("v%0d_done_req", idx), bus_req, 1'b0);
        check($sformatf("v%0d_stall_cycles", idx), stall_n, exp_stall);
        @(negedge clk);
        #1;
        check($sformatf("v%0d_hold_rdata", idx), ReadData, e.rd);
        check($sformatf("v%0d_idle_stall", idx), Stall, 1'b0);
        check($sformatf("v%0d_idle_err", idx), LsuError, 1'b0);
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d_no_done: Stall still %b, required 0 within 40 cycles", idx, Stall);
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 3'b010, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 0,  0, 32'hDEAD_BEEF, 32'h0000_1004, 32'h0,         4'hF);
    vecs[1]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_0000, 3,  0, 32'hFFFF_FF80, 32'h0000_1000, 32'h0,         4'hF);
    vecs[2]  = mk(1, 0, 3'b100, 32'h0000_1003, 32'h0,         32'h80FF_0000, 3,  0, 32'h0000_0080, 32'h0000_1000, 32'h0,         4'hF);
    vecs[3]  = mk(0, 1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0,         1,  0, 32'h0000_0080, 32'h0000_0100, 32'hABCD_ABCD, 4'hC);
    vecs[4]  = mk(1, 0, 3'b001, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 0,  0, 32'hFFFF_8001, 32'h0000_0000, 32'h0,         4'hF);
    vecs[5]  = mk(1, 0, 3'b101, 32'h0000_0000, 32'h0,         32'h8001_F00F, 0,  0, 32'h0000_F00F, 32'h0000_0000, 32'h0,         4'hF);
    vecs[6]  = mk(0, 1, 3'b000, 32'h0000_0021, 32'h0000_00A5, 32'h0,         2,  0, 32'h0000_F00F, 32'h0000_0020, 32'hA5A5_A5A5, 4'h2);
    vecs[7]  = mk(1, 1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,         0,  0, 32'h0000_F00F, 32'h0000_0040, 32'hCAFE_F00D, 4'hF);
    vecs[8]  = mk(1, 0, 3'b010, 32'h0000_1001, 32'h0,         32'h0,         0,  1, 32'h0,         32'h0,         32'h0,         4'h0);
    vecs[9]  = mk(1, 0, 3'b010, 32'h0000_2000, 32'h0,         32'h1234_5678, 0,  0, 32'h1234_5678, 32'h0000_2000, 32'h0,         4'hF);
    vecs[10] = mk(1, 0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,         0,  1, 32'h0,         32'h0,         32'h0,         4'h0);
    vecs[11] = mk(1, 0, 3'b000, 32'h0000_0002, 32'h0,         32'h0055_0000, 1,  0, 32'h0000_0055, 32'h0000_0000, 32'h0,         4'hF);
    vecs[12] = mk(1, 0, 3'b010, 32'h0000_3000, 32'h0,         32'h0,         -1, 0, 32'h0,         32'h0000_3000, 32'h0,         4'hF);
    vecs[13] = mk(0, 1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,         0,  1, 32'h0,         32'h0,         32'h0,         4'h0);
    vecs[14] = mk(1, 0, 3'b001, 32'h0000_0001, 32'h0,         32'h0,         0,  1, 32'h0,         32'h0,         32'h0,         4'h0);
    vecs[15] = mk(0, 1, 3'b001, 32'h0000_0000, 32'hFFFF_5678, 32'h0,         0,  0, 32'h0,         32'h0000_0000, 32'h5678_5678, 4'h3);
    vecs[16] = mk(1, 0, 3'b010, 32'h0000_0044, 32'h0,         32'h600D_CAFE, 2,  0, 32'h600D_CAFE, 32'h0000_0044, 32'h0,         4'hF);

    reset      = 1'b0;
    MemRead    = 1'b1;
    MemWrite   = 1'b0;
    Funct3     = 3'b011;
    Mem_WrAddr = 32'h1;
    Mem_WrData = 32'h0;
    bus_ack    = 1'b0;
    bus_rdata  = 32'h0;
    #1;
    check("rst_lsuerror", LsuError, 1'b0);
    check("rst_stall_illegal", Stall, 1'b0);
    Funct3     = 3'b010;
    Mem_WrAddr = 32'h0;
    #1;
    check("rst_stall_legal", Stall, 1'b0);
    check("rst_req", bus_req, 1'b0);
    check("rst_rdata", ReadData, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", bus_be, 4'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_we", bus_we, 1'b0);
    MemRead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("nonmem_stall", Stall, 1'b0);
    check("nonmem_err", LsuError, 1'b0);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Reset in the middle of an access, then a stray ack.
    @(negedge clk);
    MemRead    = 1'b1;
    MemWrite   = 1'b0;
    Funct3     = 3'b010;
    Mem_WrAddr = 32'h0000_4000;
    #1;
    check("rsta_accept_stall", Stall, 1'b1);
    @(negedge clk);
    #1;
    check("rsta_in_access_req", bus_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("rsta_req_drop", bus_req, 1'b0);
    check("rsta_stall", Stall, 1'b0);
    check("rsta_rdata", ReadData, 32'h0);
    check("rsta_err", LsuError, 1'b0);
    MemRead = 1'b0;
    @(negedge clk);
    reset     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rsta_ack_ignored_rdata", ReadData, 32'h0);
    check("rsta_ack_ignored_req", bus_req, 1'b0);
    check("rsta_ack_ignored_stall", Stall, 1'b0);

    run_vec(17, mk(1, 0, 3'b010, 32'h0000_4000, 32'h0, 32'h0BAD_F00D, 0, 0,
                   32'h0BAD_F00D, 32'h0000_4000, 32'h0, 4'hF));

    check("sb_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
